// File: rtl/mem_port_arb_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
// Requester count and bus widths are fixed here; the top-level and the
// order FIFO take their shapes from these constants.
package mem_port_arb_pkg;

  localparam int unsigned ArbNumReq    = 4;
  localparam int unsigned ArbAddrWidth = 32;
  localparam int unsigned ArbDataWidth = 64;
  localparam int unsigned ArbStrbWidth = ArbDataWidth / 8;
  localparam int unsigned ArbIdxWidth  = $clog2(ArbNumReq);

  typedef logic [ArbIdxWidth-1:0] idx_t;

  // Request payload of one requester
  typedef struct packed {
    logic [ArbAddrWidth-1:0] addr;
    logic [ArbDataWidth-1:0] wdata;
    logic [ArbStrbWidth-1:0] strb;
    logic                    we;
  } req_fields_t;

  // Arbitration result
  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // First valid requester at or above ptr, wrapping at ArbNumReq-1 -> 0
  function automatic pick_t rr_pick(input logic [ArbNumReq-1:0] valid, input idx_t ptr);
    pick_t res;
    idx_t  k;
    res = '0;
    for (int unsigned off = 0; off < ArbNumReq; off++) begin
      k = ArbIdxWidth'((32'(ptr) + off) % ArbNumReq);
      if (!res.found && valid[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_order_fifo.sv
// Order FIFO: remembers which requester owns each outstanding response.
// Ports: clk_i/rst_i; push_i/data_i write side; pop_i/data_o read side;
// full_o, empty_o and usage_o (fill level) status.
module mem_port_order_fifo
  import mem_port_arb_pkg::*;
#(
  parameter  int unsigned Depth    = 2,
  localparam int unsigned CntWidth = $clog2(Depth + 1),
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  idx_t                data_i,
  input  logic                pop_i,
  output idx_t                data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] usage_o
);

  idx_t                r_mem [Depth];
  logic [PtrWidth-1:0] r_wr;
  logic [PtrWidth-1:0] r_rd;
  logic [CntWidth-1:0] r_cnt;
  logic                w_push;
  logic                w_pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full_o  = (r_cnt == CntWidth'(Depth));
  assign empty_o = (r_cnt == '0);
  assign usage_o = r_cnt;
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd];

  // Pointers and fill level; reset discards any contents
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntWidth'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CntWidth'(1);
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port among
// ArbNumReq requesters, with in-order response routing via an order FIFO.
// Ports: req_* per-requester request side (packed, requester i in slice i);
// req_gnt_o/rsp_* per-requester grant and broadcast response; mem_* the
// downstream port; outstanding_o, busy_o, proto_err_o status.
module mem_port_rr_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter  int unsigned MaxOutstanding = 2,
  localparam int unsigned NumReq         = ArbNumReq,
  localparam int unsigned AddrWidth      = ArbAddrWidth,
  localparam int unsigned DataWidth      = ArbDataWidth,
  localparam int unsigned StrbWidth      = ArbStrbWidth,
  localparam int unsigned IdxWidth       = ArbIdxWidth,
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq*DataWidth-1:0] req_wdata_i,
  input  logic [NumReq*StrbWidth-1:0] req_strb_i,
  input  logic [NumReq-1:0]           req_we_i,
  output logic [NumReq-1:0]           req_gnt_o,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]        rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic [AddrWidth-1:0]        mem_addr_o,
  output logic [DataWidth-1:0]        mem_wdata_o,
  output logic [StrbWidth-1:0]        mem_strb_o,
  output logic                        mem_we_o,
  input  logic                        mem_rvalid_i,
  input  logic [DataWidth-1:0]        mem_rdata_i,
  input  logic                        mem_err_i,
  output logic [CntWidth-1:0]         outstanding_o,
  output logic                        busy_o,
  output logic                        proto_err_o
);

  idx_t        r_ptr;
  logic        r_proto_err;
  pick_t       w_pick;
  req_fields_t w_fields [NumReq];
  req_fields_t w_sel;
  logic        w_full;
  logic        w_empty;
  logic        w_hs;
  logic        w_pop;
  idx_t        w_head;

  // Unpack the per-requester request slices
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_fields[i].addr  = req_addr_i[i*AddrWidth +: AddrWidth];
      w_fields[i].wdata = req_wdata_i[i*DataWidth +: DataWidth];
      w_fields[i].strb  = req_strb_i[i*StrbWidth +: StrbWidth];
      w_fields[i].we    = req_we_i[i];
    end
  end

  assign w_pick = rr_pick(req_valid_i, r_ptr);
  // A full FIFO blocks issue even if a response pops this cycle
  assign mem_req_o = (|req_valid_i) & ~w_full;
  assign w_hs      = mem_req_o & mem_gnt_i;
  assign w_pop     = mem_rvalid_i & ~w_empty;

  // Downstream field mux; zeros when nobody is requesting
  assign w_sel       = w_pick.found ? w_fields[w_pick.idx] : '0;
  assign mem_addr_o  = w_sel.addr;
  assign mem_wdata_o = w_sel.wdata;
  assign mem_strb_o  = w_sel.strb;
  assign mem_we_o    = w_sel.we;

  // One-hot grant and response demux
  always_comb begin
    req_gnt_o   = '0;
    rsp_valid_o = '0;
    if (w_hs)  req_gnt_o[w_pick.idx] = 1'b1;
    if (w_pop) rsp_valid_o[w_head]   = 1'b1;
  end

  assign rsp_rdata_o = w_pop ? mem_rdata_i : '0;
  assign rsp_err_o   = w_pop & mem_err_i;
  assign proto_err_o = r_proto_err;
  assign busy_o      = (|req_valid_i) | (outstanding_o != '0);

  // Priority pointer advances past the winner on each handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_pick.idx == IdxWidth'(NumReq - 1)) ? '0 : w_pick.idx + IdxWidth'(1);
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_proto_err <= 1'b0;
    end else if (mem_rvalid_i && w_empty) begin
      r_proto_err <= 1'b1;
    end
  end

  mem_port_order_fifo #(
    .Depth (MaxOutstanding)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs),
    .data_i  (w_pick.idx),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .usage_o (outstanding_o)
  );

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Self-checking bench for mem_port_rr_arbiter: randomized requesters and
// downstream memory against a queue-based reference model.
module tb_mem_port_rr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned MO = 2;
  localparam int unsigned CW = $clog2(MO + 1);

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_strb;
  logic [NR-1:0]     req_we;
  logic [NR-1:0]     req_gnt;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_gnt;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [SW-1:0]     mem_strb;
  logic              mem_we;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  logic              mem_err;
  logic [CW-1:0]     outstanding;
  logic              busy;
  logic              proto_err;

  mem_port_rr_arbiter #(.MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_strb_i(req_strb), .req_we_i(req_we), .req_gnt_o(req_gnt),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_we_o(mem_we),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .outstanding_o(outstanding), .busy_o(busy), .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            p;           // priority pointer
  int            oq[$];       // owners of outstanding requests, oldest first
  longint        dq[$];       // cycle each pending response is due
  bit            perr;
  logic [NR-1:0] pend;
  logic [AW-1:0] fa [NR];
  logic [DW-1:0] fw [NR];
  logic [SW-1:0] fs [NR];
  logic          fwe [NR];
  longint        cyc = 0;
  int            lat_min = 1;
  int            lat_max = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    fa[i]   = $urandom;
    fw[i]   = {$urandom, $urandom};
    fs[i]   = SW'($urandom);
    fwe[i]  = 1'($urandom % 2);
  endtask

  task automatic drive_reqs();
    req_valid = pend;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = fa[i];
      req_wdata[i*DW +: DW] = fw[i];
      req_strb[i*SW +: SW]  = fs[i];
      req_we[i]             = fwe[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(req_gnt), 64'd0);
    check({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rdata"}, rsp_rdata, 64'd0);
    check({tag, "_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_mreq"}, 64'(mem_req), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_wdata"}, mem_wdata, 64'd0);
    check({tag, "_strb"}, 64'(mem_strb), 64'd0);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_outst"}, 64'(outstanding), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_perr"}, 64'(proto_err), 64'd0);
  endtask

  // Inputs are already driven for this cycle: compare, then advance the model
  task automatic eval_and_advance();
    int            w;
    bit            found;
    bit            exp_req;
    bit            hs;
    bit            pop_ok;
    logic [NR-1:0] exp_gnt;
    logic [NR-1:0] exp_rsp;
    longint        due;
    found = 0;
    w = 0;
    for (int off = 0; off < NR; off++) begin
      int k;
      k = (p + off) % NR;
      if (!found && pend[k]) begin
        found = 1;
        w = k;
      end
    end
    exp_req = found && (oq.size() < MO);
    hs      = exp_req && mem_gnt;
    exp_gnt = '0;
    if (hs) exp_gnt[w] = 1'b1;
    pop_ok  = mem_rvalid && (oq.size() > 0);
    exp_rsp = '0;
    if (pop_ok) exp_rsp[oq[0]] = 1'b1;
    #1;
    check("mem_req", 64'(mem_req), 64'(exp_req));
    check("req_gnt", 64'(req_gnt), 64'(exp_gnt));
    check("mem_addr", 64'(mem_addr), found ? 64'(fa[w]) : 64'd0);
    check("mem_wdata", mem_wdata, found ? fw[w] : 64'd0);
    check("mem_strb", 64'(mem_strb), found ? 64'(fs[w]) : 64'd0);
    check("mem_we", 64'(mem_we), found ? 64'(fwe[w]) : 64'd0);
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    check("rsp_rdata", rsp_rdata, pop_ok ? mem_rdata : 64'd0);
    check("rsp_err", 64'(rsp_err), pop_ok ? 64'(mem_err) : 64'd0);
    check("outstanding", 64'(outstanding), 64'(oq.size()));
    check("busy", 64'(busy), 64'((|pend) || (oq.size() > 0)));
    check("proto_err", 64'(proto_err), 64'(perr));
    @(posedge clk);
    if (mem_rvalid) begin
      if (oq.size() > 0) void'(oq.pop_front());
      else perr = 1;
      if (dq.size() > 0) void'(dq.pop_front());
    end
    if (hs) begin
      oq.push_back(w);
      p = (w + 1) % NR;
      pend[w] = 1'b0;
      due = cyc + longint'($urandom_range(lat_max, lat_min));
      if (dq.size() > 0 && due <= dq[$]) due = dq[$] + 1;
      dq.push_back(due);
    end
    cyc++;
  endtask

  task automatic run_phase(input int n, input int dens, input int gpct,
                           input int lmin, input int lmax, input int spct);
    lat_min = lmin;
    lat_max = lmax;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        if (!pend[i] && ($urandom % 100) < 32'(dens)) new_req(i);
      drive_reqs();
      mem_gnt = (($urandom % 100) < 32'(gpct));
      if (dq.size() > 0 && dq[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {$urandom, $urandom};
        mem_err    = (($urandom % 8) == 0);
      end else if (dq.size() == 0 && ($urandom % 100) < 32'(spct)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {$urandom, $urandom};
        mem_err    = 1'b0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_err    = 1'b0;
      end
      eval_and_advance();
    end
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst = 1'b1;
    pend = '0;
    drive_reqs();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;
    #1;
    check_all_zero(tag);
    p = 0;
    oq.delete();
    dq.delete();
    perr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pend = '0;
    for (int i = 0; i < NR; i++) begin
      fa[i] = '0; fw[i] = '0; fs[i] = '0; fwe[i] = 1'b0;
    end
    drive_reqs();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;
    p = 0;
    perr = 0;
    reset_dut("rst0");

    // Requester 2 alone, then its response, then pointer should sit at 3
    lat_min = 1;
    lat_max = 1;
    @(negedge clk);
    new_req(2);
    fa[2] = 32'h40;
    fwe[2] = 1'b0;
    drive_reqs();
    mem_gnt = 1'b1;
    #1;
    check("dir_gnt2", 64'(req_gnt), 64'h4);
    check("dir_addr2", 64'(mem_addr), 64'h40);
    eval_and_advance();
    @(negedge clk);
    drive_reqs();
    mem_rvalid = 1'b1;
    mem_rdata = '0;
    #1;
    check("dir_rsp2", 64'(rsp_valid), 64'h4);
    check("dir_rdata2", rsp_rdata, 64'h0);
    eval_and_advance();
    @(negedge clk);
    for (int i = 0; i < NR; i++) new_req(i);
    drive_reqs();
    mem_rvalid = 1'b0;
    #1;
    check("dir_ptr3", 64'(req_gnt), 64'h8);
    eval_and_advance();

    run_phase(40, 100, 100, 1, 1, 0);   // full load, 1-cycle latency
    run_phase(3, 100, 0, 1, 1, 0);      // grant withheld
    run_phase(30, 100, 100, 4, 4, 0);   // latency beyond FIFO depth
    run_phase(400, 60, 70, 1, 5, 0);    // mixed traffic
    run_phase(20, 0, 100, 1, 1, 30);    // drain, then stray responses
    run_phase(5, 100, 100, 3, 3, 0);    // build up outstanding work
    reset_dut("rst_mid");

    // A late response after reset counts as a protocol error
    @(negedge clk);
    drive_reqs();
    mem_rvalid = 1'b1;
    mem_rdata = {$urandom, $urandom};
    eval_and_advance();
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    eval_and_advance();
    check("late_perr", 64'(proto_err), 64'h1);

    run_phase(200, 50, 60, 1, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
